// File: rtl/arb_pkg.sv
// Shared constants and FSM state encoding for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int ARB_N        = 4;
    localparam int ARB_IDX_W    = 2;
    localparam int ARB_MAX_HOLD = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/onehot_enc4.sv
// 4-bit one-hot to 2-bit index encoder; zero or multi-hot input encodes to 0.
module onehot_enc4
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     onehot,
    output logic [ARB_IDX_W-1:0] idx
);

    // Only legal one-hot codes map to a non-zero index.
    always_comb begin
        idx = 2'd0;
        case (onehot)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters; grant held until done, req drop or en low.
// Optional forced release after ARB_MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter4
    import arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ARB_N-1:0]     req,
    input  logic                 done,
    output logic [ARB_N-1:0]     gnt,
    output logic [ARB_IDX_W-1:0] gnt_idx,
    output logic                 gnt_vld,
    output logic                 timeout
);

    arb_state_e           state_r;
    logic [ARB_N-1:0]     gnt_r;
    logic                 gnt_vld_r;
    logic [ARB_IDX_W-1:0] ptr_r;
    logic [ARB_IDX_W-1:0] owner_r;
    logic                 timeout_r;

    logic [ARB_IDX_W-1:0] cand_s;
    logic [ARB_IDX_W-1:0] pick_s;
    logic                 pick_vld_s;
    logic                 rel_s;
    logic                 force_s;

    // Search from ptr upward; iterating from the far end lets the nearest requester win.
    always_comb begin
        cand_s     = 2'd0;
        pick_s     = 2'd0;
        pick_vld_s = 1'b0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            cand_s     = ptr_r + ARB_IDX_W'(i);
            pick_s     = req[cand_s] ? cand_s : pick_s;
            pick_vld_s = pick_vld_s | req[cand_s];
        end
    end

    assign rel_s = done | ~req[owner_r] | ~en;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(ARB_MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_r;

    // Hold counter: zero while idle so each grant starts counting from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if (state_r == ST_GRANT) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end
    end

    assign force_s = (state_r == ST_GRANT) && (hold_cnt_r == HOLD_W'(ARB_MAX_HOLD - 1));
`else
    assign force_s = 1'b0;
`endif

    // Arbitration FSM with registered grant, valid, pointer and timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gnt_r     <= 4'b0000;
            gnt_vld_r <= 1'b0;
            ptr_r     <= 2'd0;
            owner_r   <= 2'd0;
            timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timeout_r <= 1'b0;
                    if (en && pick_vld_s) begin
                        state_r   <= ST_GRANT;
                        gnt_r     <= ARB_N'(1) << pick_s;
                        gnt_vld_r <= 1'b1;
                        owner_r   <= pick_s;
                    end
                end
                ST_GRANT: begin
                    if (rel_s || force_s) begin
                        state_r   <= ST_IDLE;
                        gnt_r     <= 4'b0000;
                        gnt_vld_r <= 1'b0;
                        ptr_r     <= owner_r + 2'd1;
                        // A normal release on the same edge suppresses the timeout flag.
                        timeout_r <= force_s & ~rel_s;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    gnt_r     <= 4'b0000;
                    gnt_vld_r <= 1'b0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    onehot_enc4 u_enc (
        .onehot (gnt_r),
        .idx    (gnt_idx)
    );

    assign gnt     = gnt_r;
    assign gnt_vld = gnt_vld_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed scoreboard bench for rr_arbiter4; timeout steps run when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] gnt;
        logic       to;
        string      tag;
    } exp_t;

    exp_t sb[$];

    rr_arbiter4 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic push(input logic [3:0] g, input logic t, input string tag);
        exp_t e;
        e.gnt = g;
        e.to  = t;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_empty got gnt=%b exp an entry", gnt);
        end else begin
            e = sb.pop_front();
            tests++;
            assert (gnt === e.gnt) else begin
                fails++;
                $error("FAIL %s gnt got %b exp %b", e.tag, gnt, e.gnt);
            end
            tests++;
            assert (gnt_idx === idx_of(e.gnt)) else begin
                fails++;
                $error("FAIL %s gnt_idx got %0d exp %0d", e.tag, gnt_idx, idx_of(e.gnt));
            end
            tests++;
            assert (gnt_vld === (|e.gnt)) else begin
                fails++;
                $error("FAIL %s gnt_vld got %b exp %b", e.tag, gnt_vld, |e.gnt);
            end
            tests++;
            assert (timeout === e.to) else begin
                fails++;
                $error("FAIL %s timeout got %b exp %b", e.tag, timeout, e.to);
            end
        end
    endtask

    // One clock: drive inputs, queue the expected post-edge outputs, sample #1 after the edge.
    task automatic cyc(input logic e, input logic [3:0] r, input logic d,
                       input logic [3:0] eg, input logic et, input string tag);
        en   = e;
        req  = r;
        done = d;
        push(eg, et, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #1;
        push(4'b0000, 1'b0, "reset");
        check_out();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Rotation 0,1,2,3,0 with one idle cycle between grants.
        cyc(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, "rot0");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot0_rel");
        cyc(1'b1, 4'b1111, 1'b0, 4'b0010, 1'b0, "rot1");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot1_rel");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b0, "rot2_done_idle");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot2_rel");
        cyc(1'b1, 4'b1111, 1'b0, 4'b1000, 1'b0, "rot3");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot3_rel");
        cyc(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, "rot0_wrap");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot0_wrap_rel");

        // ptr=1: grant 1, release makes ptr=2; then req=1010 picks 3.
        cyc(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, "p1_gnt1");
        cyc(1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, "p1_rel");
        cyc(1'b1, 4'b1010, 1'b0, 4'b1000, 1'b0, "p2_pick3");
        cyc(1'b1, 4'b1010, 1'b1, 4'b0000, 1'b0, "p2_rel");
        cyc(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, "p0_pick1");
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, "reqdrop_rel");

        // No preemption by req[3] while req[1] owns; drop req[1] then 3 gets it.
        cyc(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, "hold_gnt1");
        cyc(1'b1, 4'b1010, 1'b0, 4'b0010, 1'b0, "hold_nopre_a");
        cyc(1'b1, 4'b1010, 1'b0, 4'b0010, 1'b0, "hold_nopre_b");
        cyc(1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, "owner_drop");
        cyc(1'b1, 4'b1000, 1'b0, 4'b1000, 1'b0, "then_gnt3");
        cyc(1'b1, 4'b1000, 1'b1, 4'b0000, 1'b0, "gnt3_rel");

        // en low releases a grant and blocks new ones; ptr still advances.
        cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, "en_gnt0");
        cyc(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, "en_low_rel");
        cyc(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, "en_low_idle_a");
        cyc(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, "en_low_idle_b");
        cyc(1'b1, 4'b1111, 1'b0, 4'b0010, 1'b0, "en_ptr1");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "en_ptr1_rel");
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, "noreq_idle");
        cyc(1'b1, 4'b1111, 1'b0, 4'b0100, 1'b0, "noreq_ptr2");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "noreq_ptr2_rel");

        // Simultaneous done + req drop: one release, ptr 3 -> 0.
        cyc(1'b1, 4'b1000, 1'b0, 4'b1000, 1'b0, "multi_gnt3");
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "multi_rel");
        cyc(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, "multi_ptr0");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, "multi_ptr0_rel");

`ifdef ARB_TIMEOUT_EN
        // ptr=1, only req[2]: 16 held cycles, then forced release with timeout pulse.
        cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, "to_hold_1");
        for (int k = 2; k <= 16; k++) begin
            cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, $sformatf("to_hold_%0d", k));
        end
        cyc(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, "to_force");
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, "to_pulse_end");
        // ptr=3, req[2] again; done on the 16th cycle wins over the timeout.
        cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, "tod_hold_1");
        for (int k = 2; k <= 16; k++) begin
            cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, $sformatf("tod_hold_%0d", k));
        end
        cyc(1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, "tod_done_wins");
`else
        // Without the timeout option a grant is held indefinitely.
        cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, "long_hold_1");
        for (int k = 2; k <= 24; k++) begin
            cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, $sformatf("long_hold_%0d", k));
        end
        cyc(1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, "long_rel");
`endif

        // Async reset mid-grant on requester 2, then ptr restarts at 0.
        cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, "rst_pre_gnt2");
        #2;
        rst = 1'b1;
        #1;
        push(4'b0000, 1'b0, "rst_async");
        check_out();
        @(posedge clk);
        #1;
        push(4'b0000, 1'b0, "rst_held");
        check_out();
        rst = 1'b0;
        cyc(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, "post_rst_gnt0");

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain left %0d exp 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
